// File: rtl/gat_pkg.sv
// Shared GAT types and default sizing: FSM state encoding, feature geometry
// and the derived feature-BRAM address width.
package gat_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } gat_state_e;

   localparam int unsigned GAT_DATA_WIDTH         = 8;
   localparam int unsigned GAT_NUM_SUBGRAPHS      = 2708;
   localparam int unsigned GAT_NUM_FEATURE_OUT    = 16;
   localparam int unsigned GAT_NEW_FEATURE_DEPTH  = GAT_NUM_SUBGRAPHS * GAT_NUM_FEATURE_OUT;
   localparam int unsigned GAT_NEW_FEATURE_ADDR_W = $clog2(GAT_NEW_FEATURE_DEPTH);

endpackage

// File: rtl/gat_feat_fifo.sv
// Synchronous first-word-fall-through FIFO used as the readback prefetch buffer.
// Head data is visible on rdata whenever empty is low; pop consumes it.
module gat_feat_fifo #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/gat_feat_streamer.sv
// Streams a finished layer's features out of the feature BRAM as valid/ready beats,
// hiding BRAM latency with a credit-limited prefetch FIFO. Option: GAT_FEAT_RELU_EN.
module gat_feat_streamer
   import gat_pkg::*;
#(
   parameter int unsigned DATA_WIDTH         = GAT_DATA_WIDTH,
   parameter int unsigned NUM_SUBGRAPHS      = GAT_NUM_SUBGRAPHS,
   parameter int unsigned NUM_FEATURE_OUT    = GAT_NUM_FEATURE_OUT,
   parameter int unsigned NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
   parameter int unsigned NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
   parameter int unsigned BRAM_RD_LATENCY    = 2,
   parameter int unsigned FIFO_DEPTH         = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic [NEW_FEATURE_ADDR_W-1:0] feat_bram_addrb,
   input  logic [DATA_WIDTH-1:0]         feat_bram_dout,
   output logic [DATA_WIDTH-1:0]         m_tdata,
   output logic                          m_tvalid,
   input  logic                          m_tready,
   output logic                          m_tlast
);

   localparam int unsigned IDX_W = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [NEW_FEATURE_ADDR_W-1:0] LAST_ADDR = NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);
   localparam logic [IDX_W-1:0]              LAST_IDX  = IDX_W'(NUM_FEATURE_OUT - 1);

   gat_state_e                    state_q, state_d;
   logic [NEW_FEATURE_ADDR_W-1:0] addr_q, addr_d;
   logic [NEW_FEATURE_ADDR_W-1:0] beat_q, beat_d;
   logic [IDX_W-1:0]              idx_q, idx_d;
   logic [BRAM_RD_LATENCY-1:0]    pipe_q, pipe_d;

   logic [DATA_WIDTH-1:0] fifo_wdata;
   logic [DATA_WIDTH-1:0] fifo_rdata;
   logic [CNT_W-1:0]      fifo_count;
   logic                  fifo_empty, fifo_full;
   logic                  issue, hs, last_hs;
   int unsigned           inflight;

   gat_feat_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (pipe_q[BRAM_RD_LATENCY-1]),
      .wdata (fifo_wdata),
      .pop   (hs),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign m_tdata         = fifo_rdata;
   assign m_tvalid        = !fifo_empty;
   assign m_tlast         = !fifo_empty && (idx_q == LAST_IDX);
   assign feat_bram_addrb = addr_q;
   assign busy            = (state_q == ISSUE) || (state_q == DRAIN);
   assign done            = (state_q == DONE);

   always_comb begin
`ifdef GAT_FEAT_RELU_EN
      fifo_wdata = feat_bram_dout[DATA_WIDTH-1] ? '0 : feat_bram_dout;
`else
      fifo_wdata = feat_bram_dout;
`endif
   end

   always_comb begin
      inflight = 0;
      for (int unsigned i = 0; i < BRAM_RD_LATENCY; i++) inflight += 32'(pipe_q[i]);
      // Credits cover both buffered beats and reads still inside the BRAM pipe.
      issue   = (state_q == ISSUE) && !fifo_full && ((32'(fifo_count) + inflight) < FIFO_DEPTH);
      hs      = !fifo_empty && m_tready;
      last_hs = hs && (beat_q == LAST_ADDR);

      state_d   = state_q;
      addr_d    = addr_q;
      beat_d    = beat_q;
      idx_d     = idx_q;
      pipe_d    = pipe_q << 1;
      pipe_d[0] = issue;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ISSUE;
               addr_d  = '0;
            end
         end
         ISSUE: begin
            if (issue) begin
               if (addr_q == LAST_ADDR) state_d = DRAIN;
               else                     addr_d  = addr_q + NEW_FEATURE_ADDR_W'(1);
            end
         end
         // The final beat can only handshake once every read has landed and
         // the FIFO holds just that beat, so it alone marks the frame end.
         DRAIN:   if (last_hs) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (hs) begin
         beat_d = (beat_q == LAST_ADDR) ? '0 : beat_q + NEW_FEATURE_ADDR_W'(1);
         idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         beat_q  <= '0;
         idx_q   <= '0;
         pipe_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         beat_q  <= beat_d;
         idx_q   <= idx_d;
         pipe_q  <= pipe_d;
      end
   end

endmodule

// File: tb/tb_gat_feat_streamer.sv
// Randomized bench for gat_feat_streamer on a 3x4 frame; expectations come from a
// per-beat model of BRAM contents (ReLU'd when GAT_FEAT_RELU_EN is defined).
module tb_gat_feat_streamer;

   localparam int unsigned DW    = 8;
   localparam int unsigned NS    = 3;
   localparam int unsigned NFO   = 4;
   localparam int unsigned DEPTH = NS * NFO;
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned LAT   = 2;
   localparam int unsigned FD    = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          m_tready = 1'b0;
   logic          busy, done, m_tvalid, m_tlast;
   logic [AW-1:0] addrb;
   logic [DW-1:0] m_tdata;
   logic [DW-1:0] dout = '0;
   logic [DW-1:0] d1 = '0;
   logic [DW-1:0] mem [16];

   int unsigned cyc = 0;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned exp_beat = 0;
   int unsigned done_cnt = 0;
   int unsigned first_cyc = 0;
   int unsigned last_cyc = 0;
   int unsigned rmode = 0;
   bit          pend_done = 1'b0;
   bit          stalled = 1'b0;
   logic [DW-1:0] stall_data = '0;

   gat_feat_streamer #(
      .DATA_WIDTH      (DW),
      .NUM_SUBGRAPHS   (NS),
      .NUM_FEATURE_OUT (NFO),
      .BRAM_RD_LATENCY (LAT),
      .FIFO_DEPTH      (FD)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .busy            (busy),
      .done            (done),
      .feat_bram_addrb (addrb),
      .feat_bram_dout  (dout),
      .m_tdata         (m_tdata),
      .m_tvalid        (m_tvalid),
      .m_tready        (m_tready),
      .m_tlast         (m_tlast)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Two-stage BRAM read model
   always @(posedge clk) begin
      d1   <= mem[addrb];
      dout <= d1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] model(input int unsigned i);
      logic [DW-1:0] v;
      v = mem[i];
`ifdef GAT_FEAT_RELU_EN
      if ($signed(v) < 0) v = '0;
`endif
      return v;
   endfunction

   // Sink-ready driver: 0 always, 1 one-in-three, 2 random, 3 stalled
   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (rmode)
            0:       m_tready = 1'b1;
            1:       m_tready = (cyc % 3 == 0);
            2:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
         endcase
      end
   end

   // Stream monitor / scoreboard
   always @(negedge clk) begin
      if (rst) begin
         pend_done = 1'b0;
         stalled   = 1'b0;
      end else begin
         check("done", done, pend_done);
         if (pend_done) check("busy_at_done", busy, 0);
         if (done) done_cnt++;
         pend_done = 1'b0;
         if (stalled) begin
            check("hold_valid", m_tvalid, 1);
            check("hold_data", m_tdata, stall_data);
         end
         if (busy) check("addr_lead", (32'(addrb) <= exp_beat + FD), 1);
         if (m_tvalid && m_tready) begin
            if (exp_beat >= DEPTH) begin
               check("extra_beat", exp_beat, DEPTH - 1);
            end else begin
               check("data", m_tdata, model(exp_beat));
               check("last", m_tlast, (exp_beat % NFO) == NFO - 1);
               if (exp_beat == 0) first_cyc = cyc;
               if (exp_beat == DEPTH - 1) begin
                  last_cyc  = cyc;
                  pend_done = 1'b1;
               end
            end
            exp_beat++;
         end
         stalled    = m_tvalid && !m_tready;
         stall_data = m_tdata;
      end
   end

   task automatic load(input int unsigned kind);
      for (int unsigned i = 0; i < 16; i++) begin
         case (kind)
            0:       mem[i] = DW'(i);
            1:       mem[i] = DW'($urandom);
            default: case (i % 4)
                        0: mem[i] = 8'h7F;
                        1: mem[i] = 8'h80;
                        2: mem[i] = 8'hFF;
                        default: mem[i] = 8'h01;
                     endcase
         endcase
      end
   endtask

   task automatic pulse_start(output int unsigned t);
      @(posedge clk);
      #1 start = 1'b1;
      t = cyc;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int unsigned budget);
      int unsigned d0, n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("frame_done", done_cnt - d0, 1);
   endtask

   task automatic wait_beats(input int unsigned nb, input int unsigned budget);
      int unsigned n;
      n = 0;
      while (exp_beat < nb && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("beat_wait", exp_beat >= nb, 1);
   endtask

   task automatic run_frame(input int unsigned mode);
      int unsigned t;
      rmode    = mode;
      exp_beat = 0;
      pulse_start(t);
      wait_done(400);
      check("frame_beats", exp_beat, DEPTH);
   endtask

   initial begin
      int unsigned t, d0;
      logic [AW-1:0] frozen;

      load(0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", m_tvalid, 0);
      check("rst_last", m_tlast, 0);
      check("rst_data", m_tdata, 0);
      check("rst_addr", addrb, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Basic frame, full throughput
      rmode    = 0;
      exp_beat = 0;
      pulse_start(t);
      @(negedge clk);
      check("busy_t1", busy, 1);
      check("addr_t1", addrb, 0);
      wait_done(100);
      check("first_beat_cyc", first_cyc, t + 4);
      check("last_beat_cyc", last_cyc, t + 4 + DEPTH - 1);
      check("basic_beats", exp_beat, DEPTH);

      // Backpressure patterns
      load(1);
      run_frame(1);
      load(1);
      run_frame(2);

      // Long stall mid-frame
      load(1);
      rmode    = 0;
      exp_beat = 0;
      pulse_start(t);
      wait_beats(3, 50);
      rmode = 3;
      repeat (10) @(negedge clk);
      frozen = addrb;
      repeat (10) @(negedge clk);
      check("stall_addr_frozen", addrb, frozen);
      check("stall_addr_credit", addrb, exp_beat + FD);
      check("stall_valid", m_tvalid, 1);
      rmode = 0;
      wait_done(100);
      check("stall_beats", exp_beat, DEPTH);

      // start while busy is ignored, then start right after done
      load(1);
      d0       = done_cnt;
      rmode    = 2;
      exp_beat = 0;
      pulse_start(t);
      repeat (6) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(200);
      exp_beat = 0;
      pulse_start(t);
      wait_done(200);
      check("second_frame_beats", exp_beat, DEPTH);
      repeat (15) @(negedge clk);
      check("done_count", done_cnt - d0, 2);

      // Reset mid-frame
      load(1);
      d0       = done_cnt;
      rmode    = 0;
      exp_beat = 0;
      pulse_start(t);
      wait_beats(5, 50);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_valid", m_tvalid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_addr", addrb, 0);
      repeat (10) @(negedge clk);
      check("midrst_no_done", done_cnt - d0, 0);
      load(1);
      run_frame(2);

      // ReLU pattern (pass-through in the default build)
      load(2);
      run_frame(0);
      load(2);
      run_frame(2);

      // Extra random frames
      for (int k = 0; k < 3; k++) begin
         load(1);
         run_frame(32'($urandom_range(0, 2)));
      end

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_err);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/gat_feat_streamer.md
# gat_feat_streamer

Readback stage downstream of the GAT top. Once a layer completes, it walks the new-feature BRAM read port (`feat_bram_addrb` / `feat_bram_dout`) from address 0 to the last feature, hides the BRAM read latency with a credit-limited prefetch FIFO, and emits features as a valid/ready stream with a per-node `last` marker. It is the path by which results leave the accelerator toward the DMA / host interface.

## Interface
- `DATA_WIDTH`, 8: feature element width; matches `feat_bram_dout`.
- `NUM_SUBGRAPHS`, 2708: nodes per layer output.
- `NUM_FEATURE_OUT`, 16: features per node.
- `NEW_FEATURE_DEPTH`, `NUM_SUBGRAPHS*NUM_FEATURE_OUT`: total beats per frame.
- `NEW_FEATURE_ADDR_W`, `$clog2(NEW_FEATURE_DEPTH)`: read address width.
- `BRAM_RD_LATENCY`, 2: cycles from `feat_bram_addrb` to valid `feat_bram_dout`.
- `FIFO_DEPTH`, 4: prefetch entries; must be ≥ `BRAM_RD_LATENCY+2`.
- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: one-cycle pulse; begins a frame when idle.
- `busy`  out  1: high from accepted `start` until `done`.
- `done`  out  1: one-cycle pulse after the final beat handshakes.
- `feat_bram_addrb`  out  `NEW_FEATURE_ADDR_W`: registered read address into the feature BRAM.
- `feat_bram_dout`  in  `DATA_WIDTH`: BRAM read data.
- `m_tdata`  out  `DATA_WIDTH`: feature value.
- `m_tvalid`  out  1: data valid.
- `m_tready`  in  1: sink ready.
- `m_tlast`  out  1: high on the last feature (index `NUM_FEATURE_OUT-1`) of each node.

## Operation
- FSM states: IDLE → ISSUE on `start`; ISSUE → DRAIN after issuing address `NEW_FEATURE_DEPTH-1`; DRAIN → DONE when the FIFO is empty, no reads are in flight and the last beat has handshaken; DONE → IDLE unconditionally. `done` is asserted in the DONE state.
- `start` is ignored while `busy`.
- Read issue: in ISSUE, a read is issued (address incremented) only when `fifo_count + inflight < FIFO_DEPTH`. `inflight` counts reads issued whose data has not yet been written to the FIFO.
- In-flight tracking: a valid-bit shift register of length `BRAM_RD_LATENCY` follows each issued read. Its output writes `feat_bram_dout` into the FIFO. FIFO overflow is therefore impossible by construction.
- Output: `m_tdata`/`m_tvalid` come from the FIFO head. A pop occurs on `m_tvalid && m_tready`.
- `m_tdata` is held stable while `m_tvalid && !m_tready`.
- Last marker: a beat counter `feat_idx` (0..`NUM_FEATURE_OUT-1`) advances per handshake and wraps. `m_tlast = m_tvalid && feat_idx==NUM_FEATURE_OUT-1`.
- Frame end: a frame beat counter detects the final handshake (`NEW_FEATURE_DEPTH-1`).
- Simultaneous FIFO push and pop leave the count unchanged.
- Reset values: `busy=0`, `done=0`, `m_tvalid=0`, `m_tlast=0`, `m_tdata=0`, `feat_bram_addrb=0`. All counters and the FIFO are cleared, and the in-flight pipe is flushed. `rst` mid-frame abandons the frame with no `done` pulse.

## Timing
- With `start` sampled at cycle T: `busy=1` at T+1 and `feat_bram_addrb=0` at T+1. First `m_tvalid` is at T+2+`BRAM_RD_LATENCY` (T+4 at defaults).
- Throughput is 1 beat/cycle with `m_tready` held high. Any stall stops issue within 1 cycle once credits are exhausted.
- `done` asserts exactly 1 cycle after the final handshake. `busy` falls in the same cycle that `done` asserts.
- `feat_bram_addrb` holds its last value after the frame.

## Configuration
- `GAT_FEAT_RELU_EN` defined: `m_tdata` is ReLU'd, i.e. a signed value with MSB=1 is output as 0. Clamping is applied at FIFO write, so latency is unchanged.
- `GAT_FEAT_RELU_EN` undefined: `m_tdata` is passed through bit-exact.

## Structure
- Shared package `gat_pkg` holds: the FSM state enum (`IDLE`, `ISSUE`, `DRAIN`, `DONE`), the default `NUM_SUBGRAPHS`/`NUM_FEATURE_OUT`/`DATA_WIDTH` constants, and a `clog2`-derived address width.
- Sub-module `gat_feat_fifo`: a synchronous FIFO with parameters `WIDTH`/`DEPTH`, first-word-fall-through output, and ports push/pop/count/empty/full. The top level contains the FSM, the credit counter, the latency pipe and the beat counters.

## Test plan
- Basic frame (`NUM_SUBGRAPHS=3`, `NUM_FEATURE_OUT=4`, BRAM[i]=i, `m_tready=1`) → 12 beats with values 0..11 on consecutive cycles from T+4. `m_tlast` is high on beats 3, 7, 11. `done` is high at the cycle after beat 11.
- Backpressure: `m_tready` toggled in a 1-in-3 pattern → data ordering is preserved and no beat is duplicated or lost. `addrb` never runs more than `FIFO_DEPTH` ahead of the accepted beats. `m_tdata` is stable while stalled.
- Long stall: `m_tready=0` for 20 cycles mid-frame → FIFO fills to 4 and `addrb` freezes. After release, the stream resumes in order.
- `start` pulsed while busy → ignored, and exactly one `done` is produced. Then `start` right after `done` → a second identical frame.
- Reset mid-frame (`rst` at beat 5) → next cycle `m_tvalid=0`, `busy=0`, no `done`. A new `start` restarts from address 0 with no stale data.
- `GAT_FEAT_RELU_EN` with BRAM values {0x7F, 0x80, 0xFF, 0x01} → outputs {0x7F, 0x00, 0x00, 0x01}. Without the macro → outputs equal the inputs.
